// File: rtl/riscv_test_checker.sv
`default_nettype none
// ============================================================================
// Module   : riscv_test_checker
// Purpose  : Compares a core's output port against a table of expected
//            results keyed by retired-instruction count; reports pass/fail.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_test_checker #(
  parameter int NUM_TEST     = 17,
  parameter int IWIDTH       = 5,
  parameter int DWIDTH       = 32,
  parameter int TIMEOUT      = 100000,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              TBL_WE,
  input  logic [IWIDTH-1:0] TBL_IDX,
  input  logic [31:0]       TBL_NUM_INST,
  input  logic [DWIDTH-1:0] TBL_ANS,
  input  logic [DWIDTH-1:0] TBL_MASK,
  input  logic [31:0]       NUM_INST,
  input  logic [DWIDTH-1:0] OUTPUT_PORT,
  input  logic              HALT,
  output logic              DONE,
  output logic              PASSED,
  output logic [1:0]        FAIL_CODE,
  output logic [IWIDTH-1:0] FAIL_IDX,
  output logic [DWIDTH-1:0] FAIL_VALUE,
  output logic [IWIDTH:0]   PASS_CNT,
  output logic [IWIDTH:0]   FAIL_CNT,
  output logic [31:0]       CYCLE
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_PASS = 3'd2,
    S_FAIL = 3'd3,
    S_TOUT = 3'd4
  } state_e;

  localparam int              DEPTH       = 2 ** IWIDTH;
  localparam logic [IWIDTH:0] C_NUM_TEST  = (IWIDTH + 1)'(NUM_TEST);
  localparam logic [IWIDTH:0] C_ONE       = (IWIDTH + 1)'(1);
  localparam logic [31:0]     C_TOUT_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [IWIDTH:0]     ptr_q, ptr_d;
  logic [IWIDTH:0]     pass_cnt_q, pass_cnt_d;
  logic [IWIDTH:0]     fail_cnt_q, fail_cnt_d;
  logic [1:0]          fail_code_q, fail_code_d;
  logic [IWIDTH-1:0]   fail_idx_q, fail_idx_d;
  logic [DWIDTH-1:0]   fail_value_q, fail_value_d;
  logic [31:0]         cycle_q, cycle_d;
  logic                done_q, passed_q;

  logic [31:0]         tbl_num_q  [DEPTH];
  logic [DWIDTH-1:0]   tbl_ans_q  [DEPTH];
  logic [DWIDTH-1:0]   tbl_mask_q [DEPTH];

  logic                tbl_we;
  logic                fail_now;
  logic [1:0]          code_now;
  logic [31:0]         ent_num;
  logic [DWIDTH-1:0]   ent_ans;
  logic [DWIDTH-1:0]   ent_mask;

  assign ent_num  = tbl_num_q[ptr_q[IWIDTH-1:0]];
  assign ent_ans  = tbl_ans_q[ptr_q[IWIDTH-1:0]];
  assign ent_mask = tbl_mask_q[ptr_q[IWIDTH-1:0]];

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    pass_cnt_d   = pass_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    fail_code_d  = fail_code_q;
    fail_idx_d   = fail_idx_q;
    fail_value_d = fail_value_q;
    cycle_d      = cycle_q;
    tbl_we       = 1'b0;
    fail_now     = 1'b0;
    code_now     = 2'd0;

    if (START) begin
      state_d      = S_RUN;
      ptr_d        = '0;
      pass_cnt_d   = '0;
      fail_cnt_d   = '0;
      fail_code_d  = 2'd0;
      fail_idx_d   = '0;
      fail_value_d = '0;
      cycle_d      = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tbl_we = TBL_WE && ({1'b0, TBL_IDX} < C_NUM_TEST);
        end
        S_RUN: begin
          // Only the entry under the pointer is examined; one resolution per cycle.
          if (ptr_q < C_NUM_TEST) begin
            if (NUM_INST == ent_num) begin
              if (((OUTPUT_PORT ^ ent_ans) & ent_mask) == '0) begin
                pass_cnt_d = pass_cnt_q + C_ONE;
                ptr_d      = ptr_q + C_ONE;
              end else begin
                fail_now = 1'b1;
                code_now = 2'd1;
              end
            end else if (NUM_INST > ent_num) begin
              fail_now = 1'b1;
              code_now = 2'd2;
            end
          end

          if (fail_now) begin
            fail_cnt_d = fail_cnt_q + C_ONE;
            if (fail_code_q == 2'd0) begin
              fail_code_d  = code_now;
              fail_idx_d   = ptr_q[IWIDTH-1:0];
              fail_value_d = OUTPUT_PORT;
            end
            if (STOP_ON_FAIL != 0) begin
              state_d = S_FAIL;
            end else begin
              ptr_d = ptr_q + C_ONE;
            end
          end

          if (state_d == S_RUN) begin
            if (HALT) begin
              if (ptr_d == C_NUM_TEST && fail_cnt_d == '0) begin
                state_d = S_PASS;
              end else begin
                state_d = S_FAIL;
                if (ptr_d < C_NUM_TEST && fail_code_d == 2'd0) begin
                  fail_code_d  = 2'd2;
                  fail_idx_d   = ptr_d[IWIDTH-1:0];
                  fail_value_d = OUTPUT_PORT;
                end
              end
            end else if (TIMEOUT != 0 && cycle_q == C_TOUT_LAST) begin
              state_d = S_TOUT;
              if (fail_code_d == 2'd0) begin
                fail_code_d  = 2'd3;
                fail_value_d = OUTPUT_PORT;
              end
            end else if (cycle_q != 32'hFFFF_FFFF) begin
              cycle_d = cycle_q + 32'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      fail_code_q  <= 2'd0;
      fail_idx_q   <= '0;
      fail_value_q <= '0;
      cycle_q      <= '0;
      done_q       <= 1'b0;
      passed_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_num_q[i]  <= '0;
        tbl_ans_q[i]  <= '0;
        tbl_mask_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      fail_code_q  <= fail_code_d;
      fail_idx_q   <= fail_idx_d;
      fail_value_q <= fail_value_d;
      cycle_q      <= cycle_d;
      done_q       <= (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TOUT);
      passed_q     <= (state_d == S_PASS);
      if (tbl_we) begin
        tbl_num_q[TBL_IDX]  <= TBL_NUM_INST;
        tbl_ans_q[TBL_IDX]  <= TBL_ANS;
        tbl_mask_q[TBL_IDX] <= TBL_MASK;
      end
    end
  end

  assign DONE       = done_q;
  assign PASSED     = passed_q;
  assign FAIL_CODE  = fail_code_q;
  assign FAIL_IDX   = fail_idx_q;
  assign FAIL_VALUE = fail_value_q;
  assign PASS_CNT   = pass_cnt_q;
  assign FAIL_CNT   = fail_cnt_q;
  assign CYCLE      = cycle_q;

endmodule
`default_nettype wire

// File: doc/riscv_test_checker.md
RISCV_TEST_CHECKER -- requirements
Module: riscv_test_checker

Interface
REQ-001 Parameter NUM_TEST, default 17: number of expected-result table entries (1..256).
REQ-002 Parameter IWIDTH, default 5: table index width; SHALL satisfy 2^IWIDTH >= NUM_TEST.
REQ-003 Parameter DWIDTH, default 32: width of OUTPUT_PORT, answers and masks.
REQ-004 Parameter TIMEOUT, default 100000: cycle budget in RUN; 0 disables the timeout.
REQ-005 Parameter STOP_ON_FAIL, default 1: 1 = stop at first failure; 0 = record the failure and keep checking.
REQ-006 CLK  in  1  sole clock; every flop is updated on the rising edge.
REQ-007 RST  in  1  synchronous, active-high reset.
REQ-008 START  in  1  one-cycle pulse; starts or restarts a run.
REQ-009 TBL_WE  in  1  table write strobe.
REQ-010 TBL_IDX  in  IWIDTH  table entry written.
REQ-011 TBL_NUM_INST  in  32  retired-instruction count at which the entry is checked.
REQ-012 TBL_ANS  in  DWIDTH  expected OUTPUT_PORT value.
REQ-013 TBL_MASK  in  DWIDTH  compare mask; 1 = bit compared.
REQ-014 NUM_INST  in  32  core retired-instruction count, non-decreasing during a run.
REQ-015 OUTPUT_PORT  in  DWIDTH  core output port.
REQ-016 HALT  in  1  core halt indication.
REQ-017 DONE  out  1  high in PASS, FAIL or TOUT.
REQ-018 PASSED  out  1  high only in PASS.
REQ-019 FAIL_CODE  out  2  0 = none, 1 = mismatch, 2 = missed/pending, 3 = timeout (first failure).
REQ-020 FAIL_IDX  out  IWIDTH  entry index of the first failure.
REQ-021 FAIL_VALUE  out  DWIDTH  OUTPUT_PORT captured at the first failure.
REQ-022 PASS_CNT  out  IWIDTH+1  entries passed.
REQ-023 FAIL_CNT  out  IWIDTH+1  entries failed.
REQ-024 CYCLE  out  32  cycles spent in RUN, saturating at all-ones.

Function
REQ-025 States SHALL be IDLE, RUN, PASS, FAIL and TOUT, with a 3-bit registered state.
REQ-026 Writes with TBL_WE=1 SHALL take effect only in IDLE; writes in any other state and writes with TBL_IDX>=NUM_TEST SHALL be ignored.
REQ-027 START in any state SHALL enter RUN on the next cycle, clear the pointer, both counts, CYCLE and all failure fields, and retain the table; a START in the same cycle as TBL_WE SHALL discard the write.
REQ-028 In RUN, only entry[ptr] SHALL be evaluated, so entries are checked in index order; entries SHALL be loaded in ascending TBL_NUM_INST order.
REQ-029 Match: NUM_INST == entry.num_inst and (OUTPUT_PORT ^ entry.ans) & entry.mask == 0 SHALL increment PASS_CNT and the pointer.
REQ-030 Mismatch: equal count with a masked difference SHALL record code 1.
REQ-031 Missed: NUM_INST > entry.num_inst SHALL record code 2.
REQ-032 On a mismatch or a miss, FAIL_CNT SHALL increment; FAIL_IDX, FAIL_VALUE and FAIL_CODE SHALL be captured only if FAIL_CODE==0.
REQ-033 On a mismatch or a miss, STOP_ON_FAIL=1 SHALL go to FAIL next cycle; STOP_ON_FAIL=0 SHALL advance the pointer and stay in RUN.
REQ-034 At most one entry SHALL be resolved per cycle; entries sharing a NUM_INST value resolve on successive cycles, and a later entry whose count has passed by then is reported as missed.
REQ-035 HALT in RUN SHALL be evaluated after that cycle's entry check; if ptr==NUM_TEST after the check and FAIL_CNT==0 -> PASS, else -> FAIL; pending entries SHALL set code 2 with FAIL_IDX=ptr if FAIL_CODE==0.
REQ-036 With all entries resolved and HALT low, the block SHALL remain in RUN with no further checks.
REQ-037 Timeout: TIMEOUT!=0, in RUN with CYCLE==TIMEOUT-1 and no HALT -> TOUT, code 3 if FAIL_CODE==0; HALT in the same cycle takes priority.
REQ-038 PASS, FAIL and TOUT SHALL hold until START or RST; all outputs are registered, and latency from input to status is one cycle.

Reset
REQ-039 RST SHALL override START and all other inputs, including mid-run.
REQ-040 RST SHALL force IDLE, all outputs 0, the pointer to 0 and every table entry to num_inst=0, ans=0, mask=0.

Verification
REQ-041 Load 17 entries; feed NUM_INST 4..0x46 with the matching answers; HALT at 0x46 -> PASS, PASSED=1, PASS_CNT=17, FAIL_CNT=0.
REQ-042 Entry 2 {0x8, 0x1}; OUTPUT_PORT=0x3 at NUM_INST=8, STOP_ON_FAIL=1 -> FAIL, code 1, FAIL_IDX=2, FAIL_VALUE=0x3.
REQ-043 STOP_ON_FAIL=0; entries 1 and 5 mismatch; HALT after the last entry -> FAIL, FAIL_CNT=2, PASS_CNT=15, FAIL_IDX=1.
REQ-044 NUM_INST jumps 0xa -> 0xe, skipping entry 0xc -> code 2, FAIL_IDX=4; HALT at count 0x10 with entries pending -> FAIL, code 2.
REQ-045 TIMEOUT=50, no HALT -> TOUT after 50 RUN cycles, CYCLE=49, code 3; a variant with HALT in that cycle -> PASS/FAIL instead.
REQ-046 RST asserted mid-run -> IDLE next cycle, outputs 0; table writes in RUN have no effect; TBL_MASK=0x00FF ignores upper-bit differences.
